// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder slice with registered sum, carry vector and
// group propagate/generate. Every carry is a flat sum-of-products of g, p
// and cin, so no carry waits on another carry.

// Per-bit generate/propagate cell.
module cla_gp_cell (
  input  logic a,
  input  logic b,
  output logic g,
  output logic p
);
  assign g = a & b;
  assign p = a ^ b;
endmodule

module cla_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic [4:0] cout,
  output logic       group_p,
  output logic       group_g
);
  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic [W:0]   cout;
    logic         gp;
    logic         gg;
  } res_t;

  logic [W-1:0] g, p;
  logic [W:0]   c;
  logic         gp_n, gg_n;
  res_t         res_n, res_q;

  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_bit
      cla_gp_cell u_cell (.a(a[i]), .b(b[i]), .g(g[i]), .p(p[i]));
    end
  endgenerate

  // Flattened lookahead: each carry built directly from g, p and cin.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);

  // Group terms feed a second-level lookahead; c4 reuses them so the
  // identity c4 == gg | (gp & cin) holds by construction.
  assign gp_n = &p;
  assign gg_n = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
  assign c[4] = gg_n | (gp_n & c[0]);

  // Assemble next-state result.
  always_comb begin
    res_n      = '0;
    res_n.sum  = p ^ c[W-1:0];
    res_n.cout = c;
    res_n.gp   = gp_n;
    res_n.gg   = gg_n;
  end

  // Output register; reset clears results immediately, discarding in-flight data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) res_q <= '0;
    else     res_q <= res_n;
  end

  assign sum     = res_q.sum;
  assign cout    = res_q.cout;
  assign group_p = res_q.gp;
  assign group_g = res_q.gg;
endmodule

// File: tb/tb_cla_4bit.sv
// Scoreboard bench for cla_4bit: driver pushes expected results, a monitor
// pops and compares one cycle after each issued operand set.
module tb_cla_4bit;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, b;
  logic       cin;
  logic [3:0] sum;
  logic [4:0] cout;
  logic       group_p, group_g;

  typedef struct {
    logic [3:0] a, b;
    logic       cin;
    logic [3:0] sum;
    logic [4:0] cout;
    logic       gp, gg;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic in_vld = 1'b0;
  logic out_vld;

  cla_4bit dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .group_p(group_p), .group_g(group_g)
  );

  always #5 clk = ~clk;

  // Expected-output timing: a result is due one edge after issue.
  always @(posedge clk or posedge rst) begin
    if (rst) out_vld <= 1'b0;
    else     out_vld <= in_vld;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (a=%b b=%b cin=%b)", name, act, exp, a, b, cin);
    end
  endtask

  // Independent reference: bit-serial majority carries.
  function automatic exp_t model(input logic [3:0] av, input logic [3:0] bv, input logic ci);
    exp_t e;
    logic [4:0] c;
    logic [4:0] s0;
    c[0] = ci;
    for (int k = 0; k < 4; k++)
      c[k+1] = (av[k] & bv[k]) | (av[k] & c[k]) | (bv[k] & c[k]);
    e.a = av; e.b = bv; e.cin = ci;
    e.sum  = av ^ bv ^ c[3:0];
    e.cout = c;
    e.gp   = ((av ^ bv) == 4'hF);
    s0     = {1'b0, av} + {1'b0, bv};
    e.gg   = s0[4];
    return e;
  endfunction

  task automatic issue(input exp_t e);
    @(negedge clk);
    a = e.a; b = e.b; cin = e.cin; in_vld = 1'b1;
    q.push_back(e);
  endtask

  function automatic exp_t mk(input logic [3:0] av, input logic [3:0] bv, input logic ci,
                              input logic [3:0] s, input logic [4:0] co,
                              input logic gp, input logic gg);
    exp_t e;
    e.a = av; e.b = bv; e.cin = ci; e.sum = s; e.cout = co; e.gp = gp; e.gg = gg;
    return e;
  endfunction

  // Monitor: compare DUT against the scoreboard head whenever a result is due.
  exp_t m;
  always @(negedge clk) begin
    if (out_vld) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_underflow: got result with empty queue, expected entry");
      end else begin
        m = q.pop_front();
        chk("sum", {28'd0, sum}, {28'd0, m.sum});
        chk("cout", {27'd0, cout}, {27'd0, m.cout});
        chk("group_p", {31'd0, group_p}, {31'd0, m.gp});
        chk("group_g", {31'd0, group_g}, {31'd0, m.gg});
        chk("arith", {27'd0, cout[4], sum},
            {27'd0, {1'b0, m.a} + {1'b0, m.b} + {4'd0, m.cin}});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Async reset visible before any clock edge.
    rst = 1'b1; a = 4'd0; b = 4'd0; cin = 1'b0;
    #1;
    chk("rst_sum", {28'd0, sum}, 32'd0);
    chk("rst_cout", {27'd0, cout}, 32'd0);
    chk("rst_gp", {31'd0, group_p}, 32'd0);
    chk("rst_gg", {31'd0, group_g}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Hand-computed directed vectors.
    issue(mk(4'b1010, 4'b0110, 1'b0, 4'b0000, 5'b11100, 1'b0, 1'b1));
    issue(mk(4'b1101, 4'b1110, 1'b1, 4'b1100, 5'b11111, 1'b0, 1'b1));
    issue(mk(4'b1111, 4'b0000, 1'b1, 4'b0000, 5'b11111, 1'b1, 1'b0));
    issue(mk(4'b1111, 4'b0000, 1'b0, 4'b1111, 5'b00000, 1'b1, 1'b0));
    issue(mk(4'b0101, 4'b0101, 1'b0, 4'b1010, 5'b01010, 1'b0, 1'b0));

    // Exhaustive back-to-back sweep with a reset pulse part way through.
    for (int i = 0; i < 512; i++) begin
      if (i == 300) begin
        @(negedge clk);
        in_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_sum", {28'd0, sum}, 32'd0);
        chk("midrst_cout", {27'd0, cout}, 32'd0);
        chk("midrst_gp", {31'd0, group_p}, 32'd0);
        chk("midrst_gg", {31'd0, group_g}, 32'd0);
        q.delete();
        @(posedge clk); #1;
        chk("midrst_hold_cout", {27'd0, cout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
      end
      issue(model(i[3:0], i[7:4], i[8]));
    end

    @(negedge clk); in_vld = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
